disp_in_ctrl_seq: RTL and testbench
===================================

Name: disp_in_ctrl_seq

Overview:
- Registered, parametrised display-input controller for the calculator datapath.
- Selects what the 8-digit 7-segment driver shows (OP1, OP2, result, or both operands) from the calculator FSM state.
- Adds a blink on the operand being edited, a result snapshot on entry to the result state, and OP1/OP2 auto-alternation when both operands cannot fit in 8 digits.
- Sits between the calculator FSM/ALU and the hex/BCD display driver.

Parameters:
- N, 16: operand/result width. Legal range 1..32; elaboration error otherwise.
- TICK_DIV, 100000: clk cycles per timebase tick (1 ms at 100 MHz). Must be ≥ 2.
- BLINK_TICKS, 250: ticks per blink half-period.
- ALT_TICKS, 1000: ticks per OP1/OP2 alternation half-period.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- OP1  in  N  operand 1.
- OP2  in  N  operand 2.
- result  in  N  ALU result.
- state  in  2  calculator state: 0 edit OP1, 1 edit OP2, 2 blank, 3 show result.
- BTNR  in  1  debounced "show operands" request, asynchronous to this block.
- blink_en  in  1  enables blinking in states 0/1.
- o_bin  out  32  value to display, zero-extended.
- disp8  out  1  1 = driver shows all 8 digits as two 16-bit halves.
- off  out  1  1 = display blanked.
- o_src  out  2  shown quantity: 0 OP1, 1 OP2, 2 result, 3 both/none.

Behaviour:
- One clock, one domain. Reset is asynchronous and active-low. All outputs are registered.
- Reset values: o_bin=0, disp8=0, off=1, o_src=3. Internal registers: state_q=0, result_q=0, tick counter=0, blink_phase=0, alt_phase=0, BTNR synchroniser=0.
- Latency:
  - Output reflects state/OP1/OP2/blink_en 1 cycle after they are sampled.
  - BTNR passes through a 2-FF synchroniser, so its effect appears on outputs 3 cycles after it changes.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps. A tick pulse fires on the wrap cycle.
  - blink_phase toggles every BLINK_TICKS ticks; alt_phase toggles every ALT_TICKS ticks.
- State change (state != state_q):
  - Tick counter, both tick-count accumulators, blink_phase and alt_phase clear to 0 in that cycle.
  - A new state therefore always starts visible and starting with OP1.
- Result snapshot:
  - result_q <= result on the first cycle that state==3 while state_q!=3.
  - result_q holds for the whole of state 3, so ALU changes are ignored until the state is re-entered.
- Output selection (next-state values):
  - state 0: o_bin=zext(OP1), disp8=0, off=blink_en & blink_phase, o_src=0.
  - state 1: o_bin=zext(OP2), disp8=0, off=blink_en & blink_phase, o_src=1.
  - state 2: o_bin=0, disp8=0, off=1, o_src=3.
  - state 3, synced BTNR=0: o_bin=zext(result_q), disp8=0, off=0, o_src=2.
  - state 3, synced BTNR=1, N≤16: o_bin={zext16(OP1), zext16(OP2)}, disp8=1, off=0, o_src=3.
  - state 3, synced BTNR=1, N>16: o_bin=zext(alt_phase ? OP2 : OP1), disp8=0, off=0, o_src=alt_phase.
  - A rising edge of synced BTNR clears alt_phase and the alternation accumulator, so the display starts on OP1.
- blink_en deasserted mid-blink: off drops to 0 on the next cycle. The phase keeps running.
- Operand changes in states 0/1: visible after 1 cycle, with no phase reset.
- Asynchronous reset asserted mid-operation: all registers go to their reset values immediately. After release, the first sampled state is treated as a state change.

Decomposition:
- Package disp_pkg:
  - typedef enum logic [1:0] calc_state_t {S_OP1, S_OP2, S_OFF, S_RES}.
  - typedef enum logic [1:0] disp_src_t {SRC_OP1, SRC_OP2, SRC_RES, SRC_NONE}.
- Sub-module disp_phase_gen:
  - Contains the tick prescaler plus the blink and alternation phase toggles.
  - Has a synchronous clear input driven by the state-change/BTNR-edge logic.
  - Is reused by other display blocks.

Test Plan (N=16 unless stated; TICK_DIV=4, BLINK_TICKS=2, ALT_TICKS=3):
1. Hold reset_n=0, then release with state=0, OP1=16'h1234 -> during reset off=1, o_bin=0; 1 cycle after release o_bin=32'h1234, off=0, o_src=0.
2. state=0, blink_en=1 -> off=0 for 8 cycles, then 1 for 8, repeating. Set blink_en=0 mid-blank -> off=0 next cycle.
3. Change state 0->3 with result=16'hBEEF, then change result to 16'h0001 while in state 3 -> o_bin stays 32'hBEEF. Leave state 3 and re-enter -> 32'h0001.
4. state=3, OP1=16'hAAAA, OP2=16'h5555, raise BTNR -> 3 cycles later o_bin=32'hAAAA5555, disp8=1. Drop BTNR -> back to result with disp8=0.
5. N=24: state=3, BTNR=1, OP1=24'h123456, OP2=24'hABCDEF -> o_bin alternates 32'h123456 / 32'hABCDEF every 12 cycles, starting with OP1, disp8=0.
6. state=2 with any inputs -> off=1, o_bin=0. Pulse reset_n low during a state-3 alternation -> outputs at reset values immediately.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types for the calculator display-input path: calculator FSM states and display source codes.
package disp_pkg;
  typedef enum logic [1:0] {S_OP1, S_OP2, S_OFF, S_RES} calc_state_t;
  typedef enum logic [1:0] {SRC_OP1, SRC_OP2, SRC_RES, SRC_NONE} disp_src_t;
endpackage

// File: rtl/disp_phase_gen.sv
// Timebase prescaler plus blink and alternation phase toggles; exposes the next-cycle phase values
// so a registered consumer lines up with the phase register itself. clr clears everything, alt_clr only alternation.
module disp_phase_gen #(
  parameter int TICK_DIV    = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int ALT_TICKS   = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic alt_clr,
  output logic blink_nxt,
  output logic alt_nxt
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam int AW = $clog2(ALT_TICKS + 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (BLINK_TICKS < 1 || ALT_TICKS < 1) begin : g_bad_ticks
    $error("BLINK_TICKS and ALT_TICKS must be at least 1");
  end

  logic [TW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          blink_q, alt_q, tick;

  always_comb begin
    tick      = (cnt_q == TW'(TICK_DIV - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    bcnt_d    = bcnt_q;
    acnt_d    = acnt_q;
    blink_nxt = blink_q;
    alt_nxt   = alt_q;
    if (tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d    = '0;
        blink_nxt = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
      if (acnt_q == AW'(ALT_TICKS - 1)) begin
        acnt_d  = '0;
        alt_nxt = ~alt_q;
      end else begin
        acnt_d = acnt_q + 1'b1;
      end
    end
    if (alt_clr) begin
      acnt_d  = '0;
      alt_nxt = 1'b0;
    end
    if (clr) begin
      cnt_d     = '0;
      bcnt_d    = '0;
      acnt_d    = '0;
      blink_nxt = 1'b0;
      alt_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      bcnt_q  <= '0;
      acnt_q  <= '0;
      blink_q <= 1'b0;
      alt_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      acnt_q  <= acnt_d;
      blink_q <= blink_nxt;
      alt_q   <= alt_nxt;
    end
  end
endmodule

// File: rtl/disp_in_ctrl_seq.sv
// Display-input controller: picks OP1/OP2/result/both for the 8-digit driver from the calculator state.
// Outputs are registered (1 cycle from state/operands, 3 cycles from BTNR through its synchroniser).
module disp_in_ctrl_seq
  import disp_pkg::*;
#(
  parameter int N           = 16,
  parameter int TICK_DIV    = 100000,
  parameter int BLINK_TICKS = 250,
  parameter int ALT_TICKS   = 1000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] OP1,
  input  logic [N-1:0] OP2,
  input  logic [N-1:0] result,
  input  logic [1:0]   state,
  input  logic         BTNR,
  input  logic         blink_en,
  output logic [31:0]  o_bin,
  output logic         disp8,
  output logic         off,
  output logic [1:0]   o_src
);
  if (N < 1 || N > 32) begin : g_bad_n
    $error("N must be in 1..32");
  end

  calc_state_t cur, state_q;
  disp_src_t   src_d;
  logic [N-1:0] result_q, res_now;
  logic [31:0]  bin_d;
  logic         started_q, btn_s1, btn_s2, btn_d;
  logic         state_chg, btn_rise, snap, blink_nxt, alt_nxt, disp8_d, off_d;

  // started_q makes the first state sampled after reset count as a change.
  assign cur       = calc_state_t'(state);
  assign state_chg = !started_q || (cur != state_q);
  assign btn_rise  = btn_s2 & ~btn_d;
  assign snap      = (cur == S_RES) && (state_q != S_RES);
  assign res_now   = snap ? result : result_q;

  disp_phase_gen #(
    .TICK_DIV   (TICK_DIV),
    .BLINK_TICKS(BLINK_TICKS),
    .ALT_TICKS  (ALT_TICKS)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (state_chg),
    .alt_clr  (btn_rise),
    .blink_nxt(blink_nxt),
    .alt_nxt  (alt_nxt)
  );

  always_comb begin
    bin_d   = '0;
    disp8_d = 1'b0;
    off_d   = 1'b1;
    src_d   = SRC_NONE;
    case (cur)
      S_OP1: begin
        bin_d = 32'(OP1);
        off_d = blink_en & blink_nxt;
        src_d = SRC_OP1;
      end
      S_OP2: begin
        bin_d = 32'(OP2);
        off_d = blink_en & blink_nxt;
        src_d = SRC_OP2;
      end
      S_OFF: ;
      S_RES: begin
        off_d = 1'b0;
        if (!btn_s2) begin
          bin_d = 32'(res_now);
          src_d = SRC_RES;
        end else if (N <= 16) begin
          bin_d   = {16'(OP1), 16'(OP2)};
          disp8_d = 1'b1;
          src_d   = SRC_NONE;
        end else begin
          // Both operands don't fit in 8 digits: alternate, always starting on OP1.
          bin_d = 32'(alt_nxt ? OP2 : OP1);
          src_d = alt_nxt ? SRC_OP2 : SRC_OP1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_OP1;
      started_q <= 1'b0;
      result_q  <= '0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      btn_d     <= 1'b0;
      o_bin     <= '0;
      disp8     <= 1'b0;
      off       <= 1'b1;
      o_src     <= SRC_NONE;
    end else begin
      started_q <= 1'b1;
      state_q   <= cur;
      if (snap) result_q <= result;
      btn_s1    <= BTNR;
      btn_s2    <= btn_s1;
      btn_d     <= btn_s2;
      o_bin     <= bin_d;
      disp8     <= disp8_d;
      off       <= off_d;
      o_src     <= src_d;
    end
  end
endmodule

// File: tb/tb_disp_in_ctrl_seq.sv
// Directed bench for disp_in_ctrl_seq: N=16 and N=24 instances, TICK_DIV=4, BLINK_TICKS=2, ALT_TICKS=3.
module tb_disp_in_ctrl_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] op1, op2, res;
  logic [1:0]  st;
  logic        btnr, ben;
  logic [31:0] bin16;
  logic        d8_16, off16;
  logic [1:0]  src16;
  logic [23:0] op1_24, op2_24, res24;
  logic [1:0]  st24;
  logic        btnr24, ben24;
  logic [31:0] bin24;
  logic        d8_24, off24;
  logic [1:0]  src24;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] a, b, r;
    logic [31:0] e_bin;
    logic        e_off;
    logic [1:0]  e_src;
  } vec_t;
  vec_t tbl[10];

  logic [31:0] sb[50];
  logic [1:0]  ss[50];
  int d8cnt, idx, j, k, m, r1, r2, r3;

  always #5 clk = ~clk;

  disp_in_ctrl_seq #(.N(16), .TICK_DIV(4), .BLINK_TICKS(2), .ALT_TICKS(3)) dut16 (
    .clk(clk), .reset_n(reset_n), .OP1(op1), .OP2(op2), .result(res), .state(st),
    .BTNR(btnr), .blink_en(ben), .o_bin(bin16), .disp8(d8_16), .off(off16), .o_src(src16)
  );

  disp_in_ctrl_seq #(.N(24), .TICK_DIV(4), .BLINK_TICKS(2), .ALT_TICKS(3)) dut24 (
    .clk(clk), .reset_n(reset_n), .OP1(op1_24), .OP2(op2_24), .result(res24), .state(st24),
    .BTNR(btnr24), .blink_en(ben24), .o_bin(bin24), .disp8(d8_24), .off(off24), .o_src(src24)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    tbl[0] = '{2'd2, 16'h0001, 16'h0002, 16'h0003, 32'h0,        1'b1, 2'd3};
    tbl[1] = '{2'd0, 16'h0001, 16'h0002, 16'h0003, 32'h00000001, 1'b0, 2'd0};
    tbl[2] = '{2'd1, 16'h0001, 16'hBEEF, 16'h0003, 32'h0000BEEF, 1'b0, 2'd1};
    tbl[3] = '{2'd2, 16'h0001, 16'hBEEF, 16'h0003, 32'h0,        1'b1, 2'd3};
    tbl[4] = '{2'd3, 16'h0001, 16'hBEEF, 16'h7777, 32'h00007777, 1'b0, 2'd2};
    tbl[5] = '{2'd3, 16'h0001, 16'hBEEF, 16'h8888, 32'h00007777, 1'b0, 2'd2};
    tbl[6] = '{2'd0, 16'hFFFF, 16'hBEEF, 16'h8888, 32'h0000FFFF, 1'b0, 2'd0};
    tbl[7] = '{2'd1, 16'hFFFF, 16'h0000, 16'h8888, 32'h00000000, 1'b0, 2'd1};
    tbl[8] = '{2'd3, 16'hFFFF, 16'h0000, 16'h0042, 32'h00000042, 1'b0, 2'd2};
    tbl[9] = '{2'd2, 16'hFFFF, 16'h0000, 16'h9999, 32'h0,        1'b1, 2'd3};

    reset_n = 1'b0;
    st = 2'd0; op1 = 16'h1234; op2 = 16'h0; res = 16'h0; btnr = 1'b0; ben = 1'b1;
    st24 = 2'd2; op1_24 = 24'h0; op2_24 = 24'h0; res24 = 24'h0; btnr24 = 1'b0; ben24 = 1'b0;
    tick();
    tick();
    chk("rst_off", 32'(off16), 32'd1);
    chk("rst_bin", bin16, 32'h0);
    chk("rst_src", 32'(src16), 32'd3);
    chk("rst_disp8", 32'(d8_16), 32'd0);
    reset_n = 1'b1;

    // Blink: 8 cycles visible, 8 blanked; blink_en drop mid-blank, operand change with no phase reset.
    for (int c = 0; c < 24; c++) begin
      ben = (c == 12 || c == 13) ? 1'b0 : 1'b1;
      op1 = (c >= 10) ? 16'h4321 : 16'h1234;
      tick();
      chk($sformatf("blink_off_%0d", c), 32'(off16), 32'(ben & ((c / 8) % 2 == 1)));
      chk($sformatf("blink_bin_%0d", c), bin16, (c >= 10) ? 32'h4321 : 32'h1234);
      if (c == 0) begin
        chk("first_src", 32'(src16), 32'd0);
        chk("first_disp8", 32'(d8_16), 32'd0);
      end
    end

    ben = 1'b1;
    for (int v = 0; v < 10; v++) begin
      st = tbl[v].st; op1 = tbl[v].a; op2 = tbl[v].b; res = tbl[v].r;
      tick();
      chk($sformatf("tbl_bin_%0d", v), bin16, tbl[v].e_bin);
      chk($sformatf("tbl_off_%0d", v), 32'(off16), 32'(tbl[v].e_off));
      chk($sformatf("tbl_src_%0d", v), 32'(src16), 32'(tbl[v].e_src));
      chk($sformatf("tbl_disp8_%0d", v), 32'(d8_16), 32'd0);
    end

    // Result snapshot held across ALU changes until state 3 is re-entered.
    st = 2'd3; res = 16'hBEEF;
    tick();
    chk("snap_bin", bin16, 32'hBEEF);
    res = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("snap_hold_%0d", c), bin16, 32'hBEEF);
    end
    st = 2'd0;
    tick();
    st = 2'd3;
    tick();
    chk("snap_reenter", bin16, 32'h0001);
    chk("snap_src", 32'(src16), 32'd2);

    // BTNR in state 3 with N=16: both operands after the 2-FF synchroniser.
    op1 = 16'hAAAA; op2 = 16'h5555; btnr = 1'b1;
    tick();
    chk("btn_lat1", bin16, 32'h0001);
    tick();
    chk("btn_lat2", bin16, 32'h0001);
    tick();
    chk("btn_both_bin", bin16, 32'hAAAA5555);
    chk("btn_both_disp8", 32'(d8_16), 32'd1);
    chk("btn_both_src", 32'(src16), 32'd3);
    btnr = 1'b0;
    tick();
    tick();
    chk("btn_drop_lat", bin16, 32'hAAAA5555);
    tick();
    chk("btn_drop_bin", bin16, 32'h0001);
    chk("btn_drop_disp8", 32'(d8_16), 32'd0);
    chk("btn_drop_src", 32'(src16), 32'd2);

    // N=24 alternation.
    st24 = 2'd3; op1_24 = 24'h123456; op2_24 = 24'hABCDEF; res24 = 24'h000777; btnr24 = 1'b1;
    d8cnt = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      sb[c] = bin24;
      ss[c] = src24;
      d8cnt += int'(d8_24);
    end
    idx = 0;
    while (idx < 49 && ss[idx] == 2'd2) idx++;
    chk("alt_first_bin", sb[idx], 32'h123456);
    chk("alt_first_src", 32'(ss[idx]), 32'd0);
    j = idx;
    while (j < 50 && sb[j] == 32'h123456) j++;
    k = j;
    while (k < 50 && sb[k] == 32'hABCDEF) k++;
    m = k;
    while (m < 50 && sb[m] == 32'h123456) m++;
    r1 = j - idx; r2 = k - j; r3 = m - k;
    chk("alt_run1_in_range", 32'(r1 >= 1 && r1 <= 12), 32'd1);
    chk("alt_run2_len", 32'(r2), 32'd12);
    chk("alt_run3_len", 32'(r3), 32'd12);
    chk("alt_op2_src", (j < 50) ? 32'(ss[j]) : 32'hFFFF_FFFF, 32'd1);
    chk("alt_disp8_never", 32'(d8cnt), 32'd0);

    // Asynchronous reset mid-alternation.
    reset_n = 1'b0;
    #1;
    chk("arst_bin24", bin24, 32'h0);
    chk("arst_off24", 32'(off24), 32'd1);
    chk("arst_src24", 32'(src24), 32'd3);
    chk("arst_disp8_24", 32'(d8_24), 32'd0);
    chk("arst_bin16", bin16, 32'h0);
    tick();
    reset_n = 1'b1;
    btnr24 = 1'b0;
    tick();
    chk("post_rst_bin24", bin24, 32'h000777);
    chk("post_rst_src24", 32'(src24), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
